// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared core constants and types for the register-file write-back arbiter slice.
package regfile_wb_arbiter_pkg;

  localparam int CORE_XLEN = 32;
  localparam int REG_AW    = 5;
  localparam int NUM_REGS  = 32;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Scoreboard of outstanding register writes plus the source-operand hazard query.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [REG_AW-1:0]   issue_rd,
  input  logic                clr_en,
  input  logic [REG_AW-1:0]   clr_rd,
  input  logic [REG_AW-1:0]   rs1,
  input  logic [REG_AW-1:0]   rs2,
  output logic [NUM_REGS-1:0] busy,
  output logic                hazard
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Clear is applied before set so a same-edge set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign hazard = busy_q[rs1] | busy_q[rs2] | (issue_valid & busy_q[issue_rd]);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester write-back arbiter (ALU/LSU) driving the register-file write port,
// with a registered output stage and a busy scoreboard.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN  = CORE_XLEN,
  parameter int RR_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  input  logic [REG_AW-1:0]   alu_rd,
  input  logic [XLEN-1:0]     alu_data,
  output logic                alu_ready,
  input  logic                lsu_valid,
  input  logic [REG_AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0]     lsu_data,
  output logic                lsu_ready,
  output logic                RegWrite,
  output logic [REG_AW-1:0]   WR,
  output logic [XLEN-1:0]     WD,
  input  logic                issue_valid,
  input  logic [REG_AW-1:0]   issue_rd,
  input  logic [REG_AW-1:0]   rs1,
  input  logic [REG_AW-1:0]   rs2,
  output logic                hazard,
  output logic [NUM_REGS-1:0] busy
);

  grant_e              last_grant_q, last_grant_d;
  logic                regwrite_q, regwrite_d;
  logic [REG_AW-1:0]   wr_q, wr_d;
  logic [XLEN-1:0]     wd_q, wd_d;

  // On contention, round-robin favours whoever did not win last time.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!rst) begin
      if (alu_valid && lsu_valid) begin
        if ((RR_EN != 0) && (last_grant_q == GRANT_ALU)) begin
          lsu_ready = 1'b1;
        end else begin
          alu_ready = 1'b1;
        end
      end else begin
        alu_ready = alu_valid;
        lsu_ready = lsu_valid;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    regwrite_d   = 1'b0;
    wr_d         = wr_q;
    wd_d         = wd_q;
    if (alu_ready) begin
      last_grant_d = GRANT_ALU;
      regwrite_d   = (alu_rd != '0);
      wr_d         = alu_rd;
      wd_d         = alu_data;
    end else if (lsu_ready) begin
      last_grant_d = GRANT_LSU;
      regwrite_d   = (lsu_rd != '0);
      wr_d         = lsu_rd;
      wd_d         = lsu_data;
    end
  end

  // Reset points the pointer at the LSU so the ALU wins the first contest.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GRANT_LSU;
      regwrite_q   <= 1'b0;
      wr_q         <= '0;
      wd_q         <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      regwrite_q   <= regwrite_d;
      wr_q         <= wr_d;
      wd_q         <= wd_d;
    end
  end

  assign RegWrite = regwrite_q;
  assign WR       = wr_q;
  assign WD       = wd_q;

  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .clr_en      (regwrite_q),
    .clr_rd      (wr_q),
    .rs1         (rs1),
    .rs2         (rs2),
    .busy        (busy),
    .hazard      (hazard)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; a second instance checks fixed priority.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, issue_valid;
  logic [4:0]  alu_rd, lsu_rd, issue_rd, rs1, rs2;
  logic [31:0] alu_data, lsu_data;

  logic        alu_ready, lsu_ready, reg_write, hazard;
  logic [4:0]  wr;
  logic [31:0] wd, busy;

  logic        fp_alu_ready, fp_lsu_ready, fp_reg_write, fp_hazard;
  logic [4:0]  fp_wr;
  logic [31:0] fp_wd, fp_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(32), .RR_EN(1)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .RegWrite(reg_write), .WR(wr), .WD(wd),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .hazard(hazard), .busy(busy)
  );

  regfile_wb_arbiter #(.XLEN(32), .RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(fp_alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(fp_lsu_ready),
    .RegWrite(fp_reg_write), .WR(fp_wr), .WD(fp_wd),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .hazard(fp_hazard), .busy(fp_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alu_valid = 1'b1; lsu_valid = 1'b1;
    #1;
    checks++;
    if ({alu_ready, lsu_ready} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_ready: got %b expected 00", {alu_ready, lsu_ready});
    end
    step();
    step();
    checks++;
    if ({reg_write, wr, wd, busy} !== '0) begin
      errors++; $display("[TB] FAIL reset_state: got RegWrite=%b WR=%0d WD=%h busy=%h expected all zero",
                         reg_write, wr, wd, busy);
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    #1;
    checks++;
    if ({alu_ready, lsu_ready} !== 2'b10) begin
      errors++; $display("[TB] FAIL single_ready: got %b expected 10", {alu_ready, lsu_ready});
    end
    step();
    alu_valid = 1'b0;
    checks++;
    if ({reg_write, wr, wd} !== {1'b1, 5'd5, 32'h1234}) begin
      errors++; $display("[TB] FAIL single_write: got RegWrite=%b WR=%0d WD=%h expected 1 5 1234",
                         reg_write, wr, wd);
    end
    step();
    checks++;
    if ({reg_write, wr, wd} !== {1'b0, 5'd5, 32'h1234}) begin
      errors++; $display("[TB] FAIL single_hold: got RegWrite=%b WR=%0d WD=%h expected 0 5 1234",
                         reg_write, wr, wd);
    end
  endtask

  task automatic test_round_robin();
    logic exp_alu;
    rst = 1'b1;
    step();
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hB2;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_alu = (i % 2 == 0);
      checks++;
      if ({alu_ready, lsu_ready} !== {exp_alu, ~exp_alu}) begin
        errors++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", i, {alu_ready, lsu_ready},
                           {exp_alu, ~exp_alu});
      end
      checks++;
      if ({fp_alu_ready, fp_lsu_ready} !== 2'b10) begin
        errors++; $display("[TB] FAIL fp_grant%0d: got %b expected 10", i, {fp_alu_ready, fp_lsu_ready});
      end
      step();
      checks++;
      if ({reg_write, wr, wd} !== {1'b1, (exp_alu ? 5'd1 : 5'd2), (exp_alu ? 32'hA1 : 32'hB2)}) begin
        errors++; $display("[TB] FAIL rr_write%0d: got RegWrite=%b WR=%0d WD=%h", i, reg_write, wr, wd);
      end
      checks++;
      if (fp_wr !== 5'd1) begin
        errors++; $display("[TB] FAIL fp_write%0d: got WR=%0d expected 1", i, fp_wr);
      end
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    step();
  endtask

  task automatic test_hazard();
    rs1 = 5'd0; rs2 = 5'd0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    checks++;
    if (hazard !== 1'b0) begin
      errors++; $display("[TB] FAIL haz_issue_idle: got %b expected 0", hazard);
    end
    step();
    issue_valid = 1'b0; rs1 = 5'd7;
    #1;
    checks++;
    if ({busy[7], hazard} !== 2'b11) begin
      errors++; $display("[TB] FAIL haz_set: got busy7=%b hazard=%b expected 1 1", busy[7], hazard);
    end
    step();
    step();
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
    #1;
    checks++;
    if (lsu_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL haz_lsu_ready: got %b expected 1", lsu_ready);
    end
    step();
    lsu_valid = 1'b0;
    #1;
    checks++;
    if ({reg_write, wr, wd, busy[7], hazard} !== {1'b1, 5'd7, 32'h77, 1'b1, 1'b1}) begin
      errors++; $display("[TB] FAIL haz_write: got RegWrite=%b WR=%0d WD=%h busy7=%b hazard=%b",
                         reg_write, wr, wd, busy[7], hazard);
    end
    step();
    checks++;
    if ({busy[7], hazard} !== 2'b00) begin
      errors++; $display("[TB] FAIL haz_clear: got busy7=%b hazard=%b expected 0 0", busy[7], hazard);
    end
    rs1 = 5'd0;
  endtask

  task automatic test_set_wins();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    alu_valid = 1'b0;
    #1;
    checks++;
    if ({reg_write, wr, busy[9], hazard} !== {1'b1, 5'd9, 1'b1, 1'b1}) begin
      errors++; $display("[TB] FAIL setwin_pre: got RegWrite=%b WR=%0d busy9=%b hazard=%b",
                         reg_write, wr, busy[9], hazard);
    end
    step();
    issue_valid = 1'b0; issue_rd = 5'd0;
    #1;
    checks++;
    if ({busy, reg_write, hazard} !== {32'h0000_0200, 1'b0, 1'b0}) begin
      errors++; $display("[TB] FAIL setwin_busy: got busy=%h RegWrite=%b hazard=%b expected 00000200 0 0",
                         busy, reg_write, hazard);
    end
  endtask

  task automatic test_rd_zero();
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h55;
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    checks++;
    if (lsu_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL rd0_ready: got %b expected 1", lsu_ready);
    end
    step();
    lsu_valid = 1'b0; issue_valid = 1'b0;
    #1;
    checks++;
    if ({reg_write, busy} !== {1'b0, 32'h0000_0200}) begin
      errors++; $display("[TB] FAIL rd0_write: got RegWrite=%b busy=%h expected 0 00000200", reg_write, busy);
    end
  endtask

  task automatic test_back_to_back_reset();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_pre_grant: got %b expected 1", alu_ready);
    end
    step();
    rst = 1'b1; lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
    #1;
    checks++;
    if ({alu_ready, lsu_ready} !== 2'b00) begin
      errors++; $display("[TB] FAIL rst_ready: got %b expected 00", {alu_ready, lsu_ready});
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({reg_write, wr, wd, busy} !== '0) begin
      errors++; $display("[TB] FAIL rst_state: got RegWrite=%b WR=%0d WD=%h busy=%h expected all zero",
                         reg_write, wr, wd, busy);
    end
    checks++;
    if ({alu_ready, lsu_ready} !== 2'b10) begin
      errors++; $display("[TB] FAIL rst_first_contest: got %b expected 10", {alu_ready, lsu_ready});
    end
    step();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
    test_reset();
    test_single_alu();
    test_round_robin();
    test_hazard();
    test_set_wins();
    test_rd_zero();
    test_back_to_back_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
